alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width (even, >=8).
REQ-002 Parameter M_EXT, default 1, 1 enables multiply/divide; 0 decodes M ops as ADD with no stall.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 valid_i  in  1  instruction present in EX.
REQ-007 flush_i  in  1  abort any in-flight multi-cycle op.
REQ-008 ALUOp  in  2  00 load/store/AUIPC, 01 branch, 10 R/I arithmetic, 11 JAL/LUI.
REQ-009 Funct7  in  7, Funct3  in  3, ImmOp  in  1 (1 = I-type).
REQ-010 src_a, src_b  in  DATA_W  operands.
REQ-011 Operation  out  4  single-cycle ALU select (alu_op_e).
REQ-012 md_result  out  DATA_W, md_sel  out  1, done  out  1, stall  out  1.

Function
REQ-013 Operation SHALL be combinational: ALUOp 00 ADD, 01 EQ, 11 PASS_B.
REQ-014 ALUOp 10: F3 000 SUB only if ImmOp=0 and F7=0100000, else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if F7=0100000 else SRL; 110 OR; 111 AND.
REQ-015 Encoding SHALL be AND 0000, OR 0001, ADD 0010, SLT 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, XOR 1001, PASS_B 1010, SLTU 1011.
REQ-016 M op = M_EXT=1, ALUOp=10, ImmOp=0, F7=0000001; F3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; Operation SHALL be ADD during M ops.
REQ-017 FSM states IDLE, BUSY, DONE.
REQ-018 IDLE & valid_i & M op & !flush_i (cycle 0): latch operands/op, count=0, go BUSY; stall=1 combinationally in cycle 0.
REQ-019 BUSY: one result bit per cycle for DATA_W cycles (cycles 1..DATA_W), stall=1; after last bit go DONE.
REQ-020 DONE (cycle DATA_W+1): done=1, md_sel=1, md_result valid, stall=0; always return to IDLE; valid_i ignored in DONE.
REQ-021 Multiply: 2*DATA_W product; MUL low half, MULH/MULHSU/MULHU high half with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-022 Divide: signed ops via magnitudes, quotient negated if signs differ, remainder takes dividend sign.
REQ-023 Divide by zero: quotient all ones, remainder = dividend, same latency.
REQ-024 DIV/REM of most-negative by -1: quotient most-negative, remainder 0, same latency.
REQ-025 flush_i in BUSY or DONE: IDLE next cycle, no done pulse; flush_i in IDLE blocks acceptance.
REQ-026 Outside DONE, md_sel=0, done=0, md_result holds its last value.

Reset
REQ-027 reset SHALL dominate flush_i and valid_i: next state IDLE, count 0, md_result 0, done 0, md_sel 0, stall 0.
REQ-028 Reset mid-BUSY SHALL discard the op; first cycle after reset accepts a new op normally.

Structure
REQ-029 Package alu_pkg SHALL hold alu_op_e, md_op_e, md_state_e and ALUOp constants.
REQ-030 Iterative shift-add/restoring core SHALL be sub-module md_iter_unit (start, op, operands, count, result); alu_seq_ctrl owns decode, FSM, sign fix-up.

Verification (DATA_W=32)
REQ-031 ALUOp=10,F3=000,F7=0100000,ImmOp=0 -> Operation=0110, stall=0; ImmOp=1 -> 0010.
REQ-032 MUL 7 x 0xFFFFFFFD -> stall cycles 0..32, done at cycle 33, md_result=0xFFFFFFEB.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9.
REQ-035 DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-036 flush_i (then reset, separately) at cycle 10 of a DIVU -> IDLE next cycle, stall=0, no done; following MUL 3x5 -> 15 at cycle 33.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU decoder and the iterative multiply/divide sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAnd   = 4'b0000,
    AluOr    = 4'b0001,
    AluAdd   = 4'b0010,
    AluSlt   = 4'b0011,
    AluSll   = 4'b0100,
    AluSrl   = 4'b0101,
    AluSub   = 4'b0110,
    AluSra   = 4'b0111,
    AluEq    = 4'b1000,
    AluXor   = 4'b1001,
    AluPassB = 4'b1010,
    AluSltu  = 4'b1011
  } alu_op_e;

  // Values match Funct3 of the RV32M encodings.
  typedef enum logic [2:0] {
    MdMul    = 3'd0,
    MdMulh   = 3'd1,
    MdMulhsu = 3'd2,
    MdMulhu  = 3'd3,
    MdDiv    = 3'd4,
    MdDivu   = 3'd5,
    MdRem    = 3'd6,
    MdRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

  localparam logic [1:0] AluOpMem    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpArith  = 2'b10;
  localparam logic [1:0] AluOpJump   = 2'b11;

  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7MExt = 7'b0000001;

  function automatic logic md_is_div(md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// One-bit-per-cycle unsigned core: shift-add multiplier and restoring divider.
// Multiply leaves the product in {hi, lo}; divide leaves quotient in lo, remainder in hi.
module md_iter_unit import alu_pkg::*; #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      step,
  input  md_op_e                    op,
  input  logic [DATA_W-1:0]         op_a,
  input  logic [DATA_W-1:0]         op_b,
  input  logic [$clog2(DATA_W)-1:0] count,
  output logic [DATA_W-1:0]         hi,
  output logic [DATA_W-1:0]         lo
);

  localparam int unsigned CW = $clog2(DATA_W);

  logic [DATA_W-1:0] a_q, b_q, hi_q, lo_q;
  logic [CW-1:0]     idx;
  logic [DATA_W:0]   add_sum, rem_shift, rem_diff;

  always_comb begin
    idx       = CW'(DATA_W - 1) - count;
    add_sum   = {1'b0, hi_q} + (b_q[count] ? {1'b0, a_q} : '0);
    // Dividend bits enter MSB first; a negative trial difference means restore.
    rem_shift = {hi_q, a_q[idx]};
    rem_diff  = rem_shift - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (start) begin
      a_q  <= op_a;
      b_q  <= op_b;
      hi_q <= '0;
      lo_q <= '0;
    end else if (step) begin
      if (md_is_div(op)) begin
        hi_q      <= rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
        lo_q[idx] <= ~rem_diff[DATA_W];
      end else begin
        hi_q <= add_sum[DATA_W:1];
        lo_q <= {add_sum[0], lo_q[DATA_W-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// EX-stage ALU operation decoder plus IDLE/BUSY/DONE sequencer for multi-cycle M ops.
// Operands are reduced to magnitudes on entry; signs are restored when the result commits.
module alu_seq_ctrl import alu_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned M_EXT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        Funct7,
  input  logic [2:0]        Funct3,
  input  logic              ImmOp,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [3:0]        Operation,
  output logic [DATA_W-1:0] md_result,
  output logic              md_sel,
  output logic              done,
  output logic              stall
);

  localparam int unsigned CW = $clog2(DATA_W);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  md_op_e            op_q, req_op;
  logic              a_neg_q, b_neg_q, b_zero_q;
  logic [DATA_W-1:0] dividend_q, result_q;
  logic              m_op, a_neg, b_neg, accept, step, commit;
  logic [DATA_W-1:0] mag_a, mag_b, iter_hi, iter_lo, quot, rem, fix;
  logic [2*DATA_W-1:0] prod;
  alu_op_e           alu_op;

  always_comb begin
    m_op   = (M_EXT != 0) && (ALUOp == AluOpArith) && !ImmOp && (Funct7 == F7MExt);
    alu_op = AluAdd;
    unique case (ALUOp)
      AluOpMem:    alu_op = AluAdd;
      AluOpBranch: alu_op = AluEq;
      AluOpJump:   alu_op = AluPassB;
      default: begin
        unique case (Funct3)
          3'b000: alu_op = (!ImmOp && Funct7 == F7Alt) ? AluSub : AluAdd;
          3'b001: alu_op = AluSll;
          3'b010: alu_op = AluSlt;
          3'b011: alu_op = AluSltu;
          3'b100: alu_op = AluXor;
          3'b101: alu_op = (Funct7 == F7Alt) ? AluSra : AluSrl;
          3'b110: alu_op = AluOr;
          3'b111: alu_op = AluAnd;
        endcase
        if (m_op) alu_op = AluAdd;
      end
    endcase
  end

  assign Operation = alu_op;

  always_comb begin
    req_op = md_op_e'(Funct3);
    a_neg  = (req_op inside {MdMulh, MdMulhsu, MdDiv, MdRem}) && src_a[DATA_W-1];
    b_neg  = (req_op inside {MdMulh, MdDiv, MdRem}) && src_b[DATA_W-1];
    mag_a  = a_neg ? -src_a : src_a;
    mag_b  = b_neg ? -src_b : src_b;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_i && m_op && !flush_i) begin
          accept  = 1'b1;
          stall   = 1'b1;
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          step    = 1'b1;
          stall   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_q == CW'(DATA_W - 1)) state_d = StDone;
        end
      end
      StDone: begin
        commit  = !flush_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      accept = 1'b0;
      step   = 1'b0;
      commit = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      op_q       <= MdMul;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      b_zero_q   <= 1'b0;
      dividend_q <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        op_q       <= req_op;
        a_neg_q    <= a_neg;
        b_neg_q    <= b_neg;
        b_zero_q   <= (src_b == '0);
        dividend_q <= src_a;
      end
      if (commit) result_q <= fix;
    end
  end

  md_iter_unit #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .step  (step),
    .op    (op_q),
    .op_a  (mag_a),
    .op_b  (mag_b),
    .count (count_q),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  always_comb begin
    prod = {iter_hi, iter_lo};
    if (a_neg_q ^ b_neg_q) prod = -prod;
    quot = (a_neg_q ^ b_neg_q) ? -iter_lo : iter_lo;
    rem  = a_neg_q ? -iter_hi : iter_hi;
    // Divide by zero bypasses the sign fix-up: all-ones quotient, untouched dividend.
    if (b_zero_q) begin
      quot = '1;
      rem  = dividend_q;
    end
    unique case (op_q)
      MdMul:                      fix = prod[DATA_W-1:0];
      MdMulh, MdMulhsu, MdMulhu:  fix = prod[2*DATA_W-1:DATA_W];
      MdDiv, MdDivu:              fix = quot;
      default:                    fix = rem;
    endcase
  end

  assign md_result = commit ? fix : result_q;
  assign done      = commit;
  assign md_sel    = commit;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl at DATA_W=32.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, valid_i, flush_i, ImmOp;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] src_a, src_b, md_result;
  logic [3:0]  Operation;
  logic        md_sel, done, stall;

  int tests = 0;
  int fails = 0;

  alu_seq_ctrl #(
    .DATA_W (32),
    .M_EXT  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .flush_i   (flush_i),
    .ALUOp     (ALUOp),
    .Funct7    (Funct7),
    .Funct3    (Funct3),
    .ImmOp     (ImmOp),
    .src_a     (src_a),
    .src_b     (src_b),
    .Operation (Operation),
    .md_result (md_result),
    .md_sel    (md_sel),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aop, input logic [6:0] f7,
                       input logic [2:0] f3, input logic imm, input logic [31:0] a,
                       input logic [31:0] b);
    valid_i = v;
    ALUOp   = aop;
    Funct7  = f7;
    Funct3  = f3;
    ImmOp   = imm;
    src_a   = a;
    src_b   = b;
  endtask

  task automatic dec(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                     input logic [2:0] f3, input logic imm, input logic [3:0] exp);
    drive(1'b1, aop, f7, f3, imm, 32'h1234, 32'h5678);
    #2;
    check(tag, Operation, exp);
  endtask

  // Full M op from cycle 0 (IDLE) through DONE at cycle 33 and one held cycle after.
  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int busy_ok;
    tick();
    drive(1'b1, 2'b10, 7'b0000001, f3, 1'b0, a, b);
    #1;
    check({tag, " c0 stall"}, stall, 1);
    check({tag, " c0 op"}, Operation, 4'b0010);
    busy_ok = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      #1;
      if (stall === 1'b1 && done === 1'b0 && md_sel === 1'b0) busy_ok++;
    end
    check({tag, " busy cycles"}, busy_ok, 32);
    tick();
    #1;
    check({tag, " done"}, done, 1);
    check({tag, " md_sel"}, md_sel, 1);
    check({tag, " done stall"}, stall, 0);
    check({tag, " result"}, md_result, exp);
    tick();
    valid_i = 1'b0;
    #1;
    check({tag, " post done"}, {md_sel, done}, 0);
    check({tag, " post hold"}, md_result, exp);
  endtask

  task automatic abort_divu(input logic use_reset);
    tick();
    drive(1'b1, 2'b10, 7'b0000001, 3'b101, 1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) tick();
    if (use_reset) reset = 1'b1;
    else flush_i = 1'b1;
    #1;
    if (use_reset) check("reset dominates stall", stall, 0);
    tick();
    reset   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check(use_reset ? "reset abort stall" : "flush abort stall", stall, 0);
    check(use_reset ? "reset abort done" : "flush abort done", {md_sel, done}, 0);
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    drive(1'b1, 2'b10, 7'b0000001, 3'b000, 1'b0, 32'd3, 32'd5);
    tick();
    #1;
    check("reset stall", stall, 0);
    check("reset done", {md_sel, done}, 0);
    check("reset md_result", md_result, 0);
    tick();
    reset   = 1'b0;
    valid_i = 1'b0;
    #1;
    check("idle stall", stall, 0);

    dec("dec load", 2'b00, 7'h00, 3'b010, 1'b1, 4'b0010);
    dec("dec branch", 2'b01, 7'h00, 3'b000, 1'b0, 4'b1000);
    dec("dec jal", 2'b11, 7'h00, 3'b000, 1'b0, 4'b1010);
    dec("dec sub", 2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0110);
    check("sub stall", stall, 0);
    dec("dec addi alt f7", 2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0010);
    dec("dec sll", 2'b10, 7'h00, 3'b001, 1'b0, 4'b0100);
    dec("dec slt", 2'b10, 7'h00, 3'b010, 1'b0, 4'b0011);
    dec("dec sltu", 2'b10, 7'h00, 3'b011, 1'b1, 4'b1011);
    dec("dec xor", 2'b10, 7'h00, 3'b100, 1'b0, 4'b1001);
    dec("dec sra", 2'b10, 7'b0100000, 3'b101, 1'b0, 4'b0111);
    dec("dec srl", 2'b10, 7'h00, 3'b101, 1'b0, 4'b0101);
    dec("dec or", 2'b10, 7'h00, 3'b110, 1'b0, 4'b0001);
    dec("dec and", 2'b10, 7'h00, 3'b111, 1'b0, 4'b0000);
    valid_i = 1'b0;
    Funct7  = 7'b0000001;
    Funct3  = 3'b001;
    #2;
    check("dec mulh as add", Operation, 4'b0010);
    check("no valid no stall", stall, 0);

    run_md("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_md("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_md("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run_md("divu 0", 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF);
    run_md("remu 0", 3'd7, 32'd9, 32'd0, 32'd9);
    run_md("div neg", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_md("rem neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_md("div neg 0", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
    run_md("rem neg 0", 3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14);

    abort_divu(1'b0);
    check("flush hold result", md_result, 32'd14);
    run_md("mul after flush", 3'd0, 32'd3, 32'd5, 32'd15);

    abort_divu(1'b1);
    check("reset clears result", md_result, 0);
    run_md("mul after reset", 3'd0, 32'd3, 32'd5, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
